// File: rtl/burst_bus_rr_scheduler.sv
// Round-robin command scheduler for the shared SDRAM burst bus.
// Read bursts are tracked in a small ID FIFO so returned beats can be steered to the issuing master.
module burst_bus_rr_scheduler #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 21,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int BURST_LEN = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_MASTERS-1:0]            m_cmd_en,
  input  logic [N_MASTERS-1:0]            m_cmd,
  input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]     m_wr_data,
  input  logic [N_MASTERS*MASK_W-1:0]     m_data_mask,
  output logic [N_MASTERS-1:0]            m_ready,
  output logic [DATA_W-1:0]               m_rd_data,
  output logic [N_MASTERS-1:0]            m_rd_valid,
  output logic                            mem_cmd_en,
  output logic                            mem_cmd,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wr_data,
  output logic [MASK_W-1:0]               mem_data_mask,
  input  logic                            mem_ready,
  input  logic [DATA_W-1:0]               mem_rd_data,
  input  logic                            mem_rd_valid,
  output logic [$clog2(MAX_OUTST):0]      outstanding,
  output logic                            err_orphan
);

  localparam int PTR_W  = $clog2(N_MASTERS);
  localparam int ID_AW  = $clog2(MAX_OUTST);
  localparam int CNT_W  = ID_AW + 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [PTR_W:0]    N_VAL     = N_MASTERS[PTR_W:0];
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(N_MASTERS - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(MAX_OUTST);

  // Unpacked per-master views of the packed command buses
  logic [ADDR_W-1:0] addr_arr [N_MASTERS];
  logic [DATA_W-1:0] wdata_arr[N_MASTERS];
  logic [MASK_W-1:0] mask_arr [N_MASTERS];

  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [ID_AW-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [ID_AW-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic              err_orphan_reg, err_orphan_next;
  logic [PTR_W-1:0]  id_mem[MAX_OUTST];

  logic [N_MASTERS-1:0] eligible;
  logic [N_MASTERS-1:0] req_rot;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_off;
  logic [PTR_W:0]       grant_sum;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic [PTR_W-1:0]     sel_idx;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 beat_hit;
  logic [PTR_W-1:0]     head_id;

  assign fifo_full  = (count_reg == FULL_CNT);
  assign fifo_empty = (count_reg == '0);

  // A full ID FIFO only blocks reads; writes never occupy a slot
  assign eligible = m_cmd_en & (m_cmd | {N_MASTERS{~fifo_full}});

  genvar gi;
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign addr_arr[gi]   = m_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi]  = m_wr_data[gi*DATA_W +: DATA_W];
      assign mask_arr[gi]   = m_data_mask[gi*MASK_W +: MASK_W];
      assign m_ready[gi]    = grant_valid && (grant_idx == PTR_W'(gi));
      assign m_rd_valid[gi] = beat_hit && (head_id == PTR_W'(gi));
    end
  endgenerate

  // Rotate requests so bit 0 is the master at rr_ptr, take the lowest set bit, rotate back
  always_comb begin
    req_rot     = N_MASTERS'({eligible, eligible} >> rr_ptr_reg);
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = PTR_W'(i);
      end
    end
    grant_sum = {1'b0, rr_ptr_reg} + {1'b0, grant_off};
    if (grant_sum >= N_VAL) begin
      grant_sum = grant_sum - N_VAL;
    end
    grant_idx   = grant_sum[PTR_W-1:0];
    grant_valid = grant_found & mem_ready;
  end

  // With no grant the mux parks on rr_ptr so the bus fields stay deterministic
  assign sel_idx       = grant_valid ? grant_idx : rr_ptr_reg;
  assign mem_cmd_en    = grant_valid;
  assign mem_cmd       = m_cmd[sel_idx];
  assign mem_addr      = addr_arr[sel_idx];
  assign mem_wr_data   = wdata_arr[sel_idx];
  assign mem_data_mask = mask_arr[sel_idx];

  assign push     = grant_valid & ~m_cmd[grant_idx];
  assign head_id  = id_mem[rd_ptr_reg];
  assign beat_hit = mem_rd_valid & ~fifo_empty;
  assign pop      = beat_hit & (beat_cnt_reg == LAST_BEAT);

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_valid) begin
      rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  always_comb begin
    wr_ptr_next     = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next     = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next      = count_reg;
    beat_cnt_next   = beat_cnt_reg;
    err_orphan_next = err_orphan_reg | (mem_rd_valid & fifo_empty);
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    if (beat_hit) begin
      beat_cnt_next = pop ? '0 : beat_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      beat_cnt_reg   <= '0;
      err_orphan_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      beat_cnt_reg   <= beat_cnt_next;
      err_orphan_reg <= err_orphan_next;
    end
  end

  // ID storage needs no reset: entries are only read while the count says they are valid
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_reg] <= grant_idx;
    end
  end

  assign m_rd_data   = mem_rd_data;
  assign outstanding = count_reg;
  assign err_orphan  = err_orphan_reg;

endmodule

// File: tb/tb_burst_bus_rr_scheduler.sv
// Directed bench for burst_bus_rr_scheduler: arbitration order, ID FIFO routing, stalls and orphan beats.
module tb_burst_bus_rr_scheduler;
  localparam int N  = 4;
  localparam int AW = 21;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  m_cmd_en, m_cmd, m_ready, m_rd_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wr_data;
  logic [N*MW-1:0] m_data_mask;
  logic [DW-1:0] m_rd_data;
  logic          mem_cmd_en, mem_cmd, mem_ready, mem_rd_valid, err_orphan;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic [MW-1:0] mem_data_mask;
  logic [2:0]    outstanding;

  int total = 0;
  int bad   = 0;
  int own[4] = '{1, 2, 3, 0};

  burst_bus_rr_scheduler #(
    .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .BURST_LEN(4), .MAX_OUTST(4)
  ) dut (
    .clk(clk), .reset(reset), .m_cmd_en(m_cmd_en), .m_cmd(m_cmd), .m_addr(m_addr),
    .m_wr_data(m_wr_data), .m_data_mask(m_data_mask), .m_ready(m_ready),
    .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid), .mem_cmd_en(mem_cmd_en),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_data_mask(mem_data_mask), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid), .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'h10000 + 32'h111 * i);
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int i);
    return 32'hCAFE0000 | DW'(i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset        = 1'b1;
    m_cmd_en     = '0;
    m_cmd        = '0;
    mem_ready    = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]      = addr_of(i);
      m_wr_data[i*DW +: DW]   = wdata_of(i);
      m_data_mask[i*MW +: MW] = MW'(1 << i);
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",   64'(m_ready), 64'(0));
    chk("rst_cmd_en",  64'(mem_cmd_en), 64'(0));
    chk("rst_outst",   64'(outstanding), 64'(0));
    chk("rst_orphan",  64'(err_orphan), 64'(0));
    chk("rst_rdvalid", 64'(m_rd_valid), 64'(0));

    // 1: all masters reading, grants rotate until the FIFO fills
    @(negedge clk); reset = 1'b0; m_cmd_en = 4'hF; m_cmd = 4'h0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("t1_grant", 64'(m_ready), 64'(4'b0001 << k));
      chk("t1_outst", 64'(outstanding), 64'(k));
      chk("t1_addr",  64'(mem_addr), 64'(addr_of(k)));
    end
    @(negedge clk); #1;
    chk("t1_full_ready", 64'(m_ready), 64'(0));
    chk("t1_full_en",    64'(mem_cmd_en), 64'(0));
    chk("t1_full_outst", 64'(outstanding), 64'(4));
    chk("t1_idle_addr",  64'(mem_addr), 64'(addr_of(0)));

    // 3: FIFO full, write from master 2 passes while master 0 read is masked
    @(negedge clk); m_cmd_en = 4'b0101; m_cmd = 4'b0100; #1;
    chk("t3_grant", 64'(m_ready), 64'(4'b0100));
    chk("t3_cmd",   64'(mem_cmd), 64'(1));
    chk("t3_mask",  64'(mem_data_mask), 64'(4'b0100));
    chk("t3_wdata", 64'(mem_wr_data), 64'(wdata_of(2)));
    chk("t3_en",    64'(mem_cmd_en), 64'(1));

    // First burst pops; read stays blocked through the popping beat
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); m_cmd_en = 4'b0001; m_cmd = 4'b0000;
      mem_rd_valid = 1'b1; mem_rd_data = 32'hD0000000 + DW'(b); #1;
      chk("t1_pop_rdv",   64'(m_rd_valid), 64'(4'b0001));
      chk("t1_pop_stall", 64'(m_ready), 64'(0));
      chk("t1_pop_data",  64'(m_rd_data), 64'(32'hD0000000 + DW'(b)));
    end
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("t1_refill_grant", 64'(m_ready), 64'(4'b0001));
    chk("t1_refill_outst", 64'(outstanding), 64'(3));
    @(negedge clk); m_cmd_en = '0; #1;
    chk("t1_refull_outst", 64'(outstanding), 64'(4));

    // Drain remaining bursts in issue order 1,2,3,0
    for (int b = 0; b < 16; b++) begin
      @(negedge clk); mem_rd_valid = 1'b1; mem_rd_data = DW'(b); #1;
      chk("drain_rdv", 64'(m_rd_valid), 64'(4'b0001 << own[b/4]));
    end
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("drain_outst", 64'(outstanding), 64'(0));
    chk("drain_rdv0",  64'(m_rd_valid), 64'(0));

    // 4: reads from m2 then m0, eight back-to-back beats
    @(negedge clk); m_cmd_en = 4'b0100; m_cmd = '0; #1;
    chk("t4_grant2", 64'(m_ready), 64'(4'b0100));
    @(negedge clk); m_cmd_en = 4'b0001; #1;
    chk("t4_grant0", 64'(m_ready), 64'(4'b0001));
    for (int b = 0; b < 8; b++) begin
      @(negedge clk); m_cmd_en = '0; mem_rd_valid = 1'b1; mem_rd_data = 32'hB0000000 + DW'(b); #1;
      chk("t4_rdv",   64'(m_rd_valid), 64'((b < 4) ? 4'b0100 : 4'b0001));
      chk("t4_outst", 64'(outstanding), 64'((b < 4) ? 2 : 1));
      chk("t4_data",  64'(m_rd_data), 64'(32'hB0000000 + DW'(b)));
    end
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("t4_outst_end", 64'(outstanding), 64'(0));

    // 2: masters 1 and 3 request with rr_ptr=2
    @(negedge clk); m_cmd_en = 4'b0010; m_cmd = 4'b0010; #1;
    chk("t2_setup", 64'(m_ready), 64'(4'b0010));
    @(negedge clk); m_cmd_en = 4'b1010; m_cmd = 4'b1010; #1;
    chk("t2_first",  64'(m_ready), 64'(4'b1000));
    @(negedge clk); #1;
    chk("t2_second", 64'(m_ready), 64'(4'b0010));

    // 5: mem_ready low for five cycles, rr_ptr must hold at 2
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); m_cmd_en = 4'hF; m_cmd = 4'hF; mem_ready = 1'b0; #1;
      chk("t5_ready", 64'(m_ready), 64'(0));
      chk("t5_en",    64'(mem_cmd_en), 64'(0));
      chk("t5_addr",  64'(mem_addr), 64'(addr_of(2)));
    end
    @(negedge clk); mem_ready = 1'b1; #1;
    chk("t5_resume", 64'(m_ready), 64'(4'b0100));

    // 6: orphan beat, then reset in the middle of a burst
    @(negedge clk); m_cmd_en = '0; m_cmd = '0; mem_rd_valid = 1'b1; #1;
    chk("t6_orphan_rdv", 64'(m_rd_valid), 64'(0));
    chk("t6_orphan_pre", 64'(err_orphan), 64'(0));
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("t6_orphan_set", 64'(err_orphan), 64'(1));
    @(negedge clk); #1;
    chk("t6_orphan_hold", 64'(err_orphan), 64'(1));
    @(negedge clk); m_cmd_en = 4'b0001; #1;
    chk("t6_grant", 64'(m_ready), 64'(4'b0001));
    for (int b = 0; b < 2; b++) begin
      @(negedge clk); m_cmd_en = '0; mem_rd_valid = 1'b1; #1;
      chk("t6_beat", 64'(m_rd_valid), 64'(4'b0001));
    end
    @(negedge clk); mem_rd_valid = 1'b0; reset = 1'b1; #1;
    chk("t6_rst_outst",  64'(outstanding), 64'(0));
    chk("t6_rst_orphan", 64'(err_orphan), 64'(0));
    @(negedge clk); reset = 1'b0; mem_rd_valid = 1'b1; #1;
    chk("t6_stale_rdv", 64'(m_rd_valid), 64'(0));
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("t6_stale_orphan", 64'(err_orphan), 64'(1));
    @(negedge clk); m_cmd_en = 4'b0010; #1;
    chk("t6_post_grant", 64'(m_ready), 64'(4'b0010));
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); m_cmd_en = '0; mem_rd_valid = 1'b1; #1;
      chk("t6_post_rdv",   64'(m_rd_valid), 64'(4'b0010));
      chk("t6_post_outst", 64'(outstanding), 64'(1));
    end
    @(negedge clk); mem_rd_valid = 1'b0; #1;
    chk("t6_post_end", 64'(outstanding), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
